// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage: widths, reset PC,
// bubble encoding, fetch FSM states and the {pc,inst} entry carried through IF.
package stage_if_pkg;

  localparam int PC_WIDTH       = 32;
  localparam int INST_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [PC_WIDTH-1:0]   RESET_PC = '0;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_S_REQ  = 2'd0,
    FETCH_S_WAIT = 2'd1,
    FETCH_S_DROP = 2'd2,
    FETCH_S_HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } if_id_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] rs1_of(input logic [INST_WIDTH-1:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] rs2_of(input logic [INST_WIDTH-1:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// Instruction-memory fetch port: request/grant address phase, then one
// rvalid/rdata response per granted request.
interface stage_if_if;
  import stage_if_pkg::*;

  logic                  req;
  logic [PC_WIDTH-1:0]   addr;
  logic                  gnt;
  logic                  rvalid;
  logic [INST_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/stage_if_skid_buf.sv
// One-entry {pc,inst} holding buffer for a fetched word that arrives while
// decode is stalled. Clear wins over load, load wins over drain.
module stage_if_skid_buf
  import stage_if_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t entry;

  always_ff @(posedge clk) begin
    if (!reset_n)   full <= 1'b0;
    else if (clear) full <= 1'b0;
    else if (load)  full <= 1'b1;
    else if (drain) full <= 1'b0;
  end

  // NOTE: the payload has no reset; it is only ever observed while full is set.
  always_ff @(posedge clk) begin
    if (load) entry <= din;
  end

  assign dout = entry;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns fetch_pc, runs one-outstanding IMEM requests,
// drops responses killed by a redirect and loads the IF/ID register.
module stage_if
  import stage_if_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pc_sel,
  input  logic [PC_WIDTH-1:0]       pc_imm,
  input  logic                      if_flush,
  input  logic                      id_stall,
  stage_if_if.master                imem,
  output logic                      if_id_valid,
  output logic [PC_WIDTH-1:0]       if_id_pc,
  output logic [INST_WIDTH-1:0]     if_id_inst,
  output logic [REG_ADDR_WIDTH-1:0] if_id_rs1,
  output logic [REG_ADDR_WIDTH-1:0] if_id_rs2
);

  fetch_state_e        state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;
  if_id_t              if_id, if_id_n;
  logic                word_take, skid_load, skid_drain, skid_full;
  fetch_entry_t        skid_out;
  logic [PC_WIDTH-1:0] target, pc_plus4;

  assign target   = align_pc(pc_imm);
  assign pc_plus4 = fetch_pc + PC_WIDTH'(4);

  stage_if_skid_buf u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (pc_sel),
    .din     ('{pc: fetch_pc, inst: imem.rdata}),
    .dout    (skid_out),
    .full    (skid_full)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    word_take  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    unique case (state)
      FETCH_S_REQ: begin
        if (pc_sel)   fetch_pc_n = target;
        if (imem.gnt) state_n = pc_sel ? FETCH_S_DROP : FETCH_S_WAIT;
      end
      FETCH_S_WAIT: begin
        if (pc_sel) begin
          fetch_pc_n = target;
          state_n    = imem.rvalid ? FETCH_S_REQ : FETCH_S_DROP;
        end else if (imem.rvalid) begin
          fetch_pc_n = pc_plus4;
          if (id_stall) begin
            skid_load = 1'b1;
            state_n   = FETCH_S_HOLD;
          end else begin
            word_take = 1'b1;
            state_n   = FETCH_S_REQ;
          end
        end
      end
      FETCH_S_DROP: begin
        if (pc_sel)      fetch_pc_n = target;
        if (imem.rvalid) state_n = FETCH_S_REQ;
      end
      FETCH_S_HOLD: begin
        if (pc_sel) begin
          fetch_pc_n = target;
          state_n    = FETCH_S_REQ;
        end else if (!id_stall) begin
          skid_drain = skid_full;
          state_n    = FETCH_S_REQ;
        end
      end
      default: state_n = FETCH_S_REQ;
    endcase
  end

  // Flush beats stall; with neither, IF/ID takes a new word or becomes a bubble.
  always_comb begin
    if_id_n = if_id;
    if (if_flush) begin
      if_id_n.valid = 1'b0;
      if_id_n.inst  = NOP_INST;
    end else if (!id_stall) begin
      if (word_take) begin
        if_id_n = '{valid: 1'b1, pc: fetch_pc, inst: imem.rdata};
      end else if (skid_drain) begin
        if_id_n = '{valid: 1'b1, pc: skid_out.pc, inst: skid_out.inst};
      end else begin
        if_id_n.valid = 1'b0;
        if_id_n.inst  = NOP_INST;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH_S_REQ;
      fetch_pc  <= RESET_PC;
      if_id     <= '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST};
      if_id_rs1 <= '0;
      if_id_rs2 <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      if_id     <= if_id_n;
      if_id_rs1 <= rs1_of(if_id_n.inst);
      if_id_rs2 <= rs2_of(if_id_n.inst);
    end
  end

  // Request is masked while reset is held so IMEM never grants a dying fetch.
  assign imem.req  = (state == FETCH_S_REQ) && reset_n;
  assign imem.addr = fetch_pc;

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_inst  = if_id.inst;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: IMEM responder model, grant-address and IF/ID scoreboards
// fed by directed scenarios, plus direct checks on stall/redirect/reset state.
module tb_stage_if;
  import stage_if_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      pc_sel;
  logic [PC_WIDTH-1:0]       pc_imm;
  logic                      if_flush;
  logic                      id_stall;
  logic                      if_id_valid;
  logic [PC_WIDTH-1:0]       if_id_pc;
  logic [INST_WIDTH-1:0]     if_id_inst;
  logic [REG_ADDR_WIDTH-1:0] if_id_rs1, if_id_rs2;

  stage_if_if imem ();

  stage_if dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_sel      (pc_sel),
    .pc_imm      (pc_imm),
    .if_flush    (if_flush),
    .id_stall    (id_stall),
    .imem        (imem),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_rs1   (if_id_rs1),
    .if_id_rs2   (if_id_rs2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [PC_WIDTH-1:0] addr_q[$];
  fetch_entry_t        ifid_q[$];

  int                  lat = 1;
  logic                pend = 1'b0;
  int                  cnt = 0;
  logic [PC_WIDTH-1:0] pend_addr = '0;
  logic [PC_WIDTH-1:0] rsp_addr = '0;

  function automatic logic [INST_WIDTH-1:0] word_at(input logic [PC_WIDTH-1:0] a);
    return {a[15:2], 2'b11, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #2;
  endtask

  task automatic push_ifid(input logic [PC_WIDTH-1:0] pc);
    ifid_q.push_back('{pc: pc, inst: word_at(pc)});
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next();
      if (if_id_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // IMEM model: response lat cycles after grant; grants checked against addr_q.
  initial begin
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    forever begin
      @(negedge clk);
      imem.rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem.rvalid = 1'b1;
          imem.rdata  = word_at(pend_addr);
          rsp_addr    = pend_addr;
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      #3;
      if (!reset_n) begin
        pend = 1'b0;
      end else if (imem.req && imem.gnt) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected: got addr %h expected no request", imem.addr);
        end else begin
          check("grant_addr", imem.addr, addr_q.pop_front());
        end
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = imem.addr;
      end
    end
  end

  // IF/ID monitor: a fresh load is any valid entry after an edge without stall/flush.
  initial begin
    logic         s_stall, s_flush, s_rst;
    fetch_entry_t e;
    forever begin
      @(posedge clk);
      s_stall = id_stall;
      s_flush = if_flush;
      s_rst   = reset_n;
      #1;
      if (s_rst && !s_stall && !s_flush && if_id_valid === 1'b1) begin
        if (ifid_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ifid_unexpected: got pc %h expected no instruction", if_id_pc);
        end else begin
          e = ifid_q.pop_front();
          check("ifid_pc",   if_id_pc,   e.pc);
          check("ifid_inst", if_id_inst, e.inst);
          check("ifid_rs1",  32'(if_id_rs1), 32'(e.inst[19:15]));
          check("ifid_rs2",  32'(if_id_rs2), 32'(e.inst[24:20]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n  = 1'b0;
    pc_sel   = 1'b0;
    pc_imm   = '0;
    if_flush = 1'b0;
    id_stall = 1'b0;
    imem.gnt = 1'b1;
    next();
    next();
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_inst",  if_id_inst, NOP_INST);
    check("rst_pc",    if_id_pc, RESET_PC);
    check("rst_req",   32'(imem.req), 32'd0);

    // Straight-line fetch, then a 3-cycle stall while the word at 0x8 returns.
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    addr_q.push_back(32'h8); addr_q.push_back(32'hC);
    push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next();
      if (imem.rvalid && rsp_addr == 32'h8) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_rsp_8", 32'(seen), 32'd1);
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      check("stall_req",   32'(imem.req), 32'd0);
      check("stall_valid", 32'(if_id_valid), 32'd0);
      check("stall_pc",    if_id_pc, 32'h4);
    end
    id_stall = 1'b0;
    next();
    check("drain_valid", 32'(if_id_valid), 32'd1);
    check("drain_pc",    if_id_pc, 32'h8);

    // Redirect with flush in S_WAIT; the late 0xC response must be dropped.
    lat = 3;
    addr_q.push_back(32'h100);
    push_ifid(32'h100);
    next();
    pc_sel = 1'b1; if_flush = 1'b1; pc_imm = 32'h100;
    next();
    pc_sel = 1'b0; if_flush = 1'b0;
    check("redir_valid", 32'(if_id_valid), 32'd0);
    check("drop_req",    32'(imem.req), 32'd0);
    lat = 1;
    wait_valid("wait_load_100");

    // Redirect (unaligned target) coincident with rvalid and stall.
    addr_q.push_back(32'h104); addr_q.push_back(32'h100);
    push_ifid(32'h100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next();
      if (imem.rvalid && rsp_addr == 32'h104) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_rsp_104", 32'(seen), 32'd1);
    pc_sel = 1'b1; if_flush = 1'b1; id_stall = 1'b1; pc_imm = 32'h103;
    next();
    pc_sel = 1'b0; if_flush = 1'b0; id_stall = 1'b0;
    check("coinc_valid", 32'(if_id_valid), 32'd0);
    check("coinc_req",   32'(imem.req), 32'd1);
    check("coinc_addr",  imem.addr, 32'h100);
    wait_valid("wait_reload_100");

    // Flush must beat stall on a valid IF/ID; redirect in S_REQ to the top of memory.
    imem.gnt = 1'b0;
    pc_sel = 1'b1; if_flush = 1'b1; id_stall = 1'b1; pc_imm = 32'hFFFF_FFFC;
    next();
    pc_sel = 1'b0; if_flush = 1'b0; id_stall = 1'b0;
    check("flush_over_stall", 32'(if_id_valid), 32'd0);
    check("top_addr", imem.addr, 32'hFFFF_FFFC);
    check("top_req",  32'(imem.req), 32'd1);
    addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
    push_ifid(32'hFFFF_FFFC);
    imem.gnt = 1'b1;
    wait_valid("wait_load_top");

    // Reset while waiting for the wrapped fetch at 0x0.
    lat = 3;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend && pend_addr == 32'h0) begin
        seen = 1'b1;
        break;
      end
      next();
    end
    check("wait_wrap_grant", 32'(seen), 32'd1);
    reset_n = 1'b0;
    next();
    check("mid_rst_valid", 32'(if_id_valid), 32'd0);
    check("mid_rst_inst",  if_id_inst, NOP_INST);
    check("mid_rst_pc",    if_id_pc, RESET_PC);
    check("mid_rst_rs1",   32'(if_id_rs1), 32'd0);
    check("mid_rst_rs2",   32'(if_id_rs2), 32'd0);
    check("mid_rst_req",   32'(imem.req), 32'd0);
    next();
    addr_q.push_back(RESET_PC);
    push_ifid(RESET_PC);
    lat = 1;
    reset_n = 1'b1;
    wait_valid("wait_after_reset");
    imem.gnt = 1'b0;
    repeat (4) next();
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    check("ifid_q_empty", 32'(ifid_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
